// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line to DRAM-burst adaptor.
// The beat count and counter width are derived from the default line and burst widths.
package cacheline_adaptor_types;

    localparam int S_LINE   = 256;
    localparam int S_BURST  = 64;
    localparam int S_OFFSET = 5;
    localparam int BEATS    = S_LINE / S_BURST;
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_DONE,
        WRITE,
        WRITE_DONE
    } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line read/write into a 4-beat 64-bit memory burst.
// Handshake: read_i/write_i are held by the cache until resp_o; memory strobes resp_i once per beat.
module cacheline_adaptor
    import cacheline_adaptor_types::*;
#(
    parameter int s_line   = S_LINE,
    parameter int s_burst  = S_BURST,
    parameter int s_offset = S_OFFSET
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         address_i,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    output logic [31:0]         address_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [s_line-1:0]      buf_q;
    logic                   last_beat;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_o <= 1'b0;
                    // A simultaneous read and write resolves to the write.
                    if (write_i || read_i) begin
                        address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
                        buf_q     <= line_i;
                        burst_o   <= line_i[s_burst-1:0];
                        cnt_q     <= '0;
                        if (write_i) begin
                            state_q <= WRITE;
                            write_o <= 1'b1;
                        end else begin
                            state_q <= READ;
                            read_o  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[s_burst*int'(cnt_q) +: s_burst] <= burst_i;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q <= READ_DONE;
                            read_o  <= 1'b0;
                            resp_o  <= 1'b1;
                        end
                    end
                end
                READ_DONE: begin
                    resp_o  <= 1'b0;
                    state_q <= IDLE;
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q <= WRITE_DONE;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                        end else begin
                            // Shift buffer: the next beat always sits just above the current one.
                            buf_q   <= buf_q >> s_burst;
                            burst_o <= buf_q[2*s_burst-1:s_burst];
                        end
                    end
                end
                WRITE_DONE: begin
                    resp_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    resp_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a scripted memory model drives beats and an
// expected-value queue holds read lines and write beats until the DUT produces them.
module tb_cacheline_adaptor;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   address_i;
    logic [255:0]  line_i;
    logic [255:0]  line_o;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [31:0]   address_o;
    logic [63:0]   burst_i;
    logic [63:0]   burst_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;

    logic [255:0]  exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic [255:0]  last_line;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .address_o (address_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input int gap, input bit check_lat);
        int cyc;
        exp_q.push_back(line);
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = addr;
        tick();
        cyc = 1;
        address_i = $urandom;
        chk("rd_read_o", read_o, 1);
        chk("rd_write_o", write_o, 0);
        chk("rd_addr", address_o, addr & 32'hffff_ffe0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                resp_i  = 1'b0;
                burst_i = {$urandom, $urandom};
                tick();
                cyc++;
                chk("rd_stall_read_o", read_o, 1);
                chk("rd_stall_resp_o", resp_o, 0);
            end
            resp_i  = 1'b1;
            burst_i = line[64*k +: 64];
            tick();
            cyc++;
        end
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        chk("rd_resp_o", resp_o, 1);
        chk("rd_read_o_done", read_o, 0);
        chk("rd_addr_stable", address_o, addr & 32'hffff_ffe0);
        chk("rd_line", line_o, exp_q.pop_front());
        if (check_lat) chk("rd_latency", cyc, 5);
        read_i = 1'b0;
        tick();
        chk("rd_resp_o_pulse", resp_o, 0);
        last_line = line;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int gap, input bit both);
        for (int k = 0; k < 4; k++) exp_q.push_back({192'b0, line[64*k +: 64]});
        write_i   = 1'b1;
        read_i    = both;
        line_i    = line;
        address_i = addr;
        tick();
        read_i    = 1'b0;
        line_i    = {8{$urandom}};
        address_i = $urandom;
        chk("wr_write_o", write_o, 1);
        chk("wr_read_o", read_o, 0);
        chk("wr_addr", address_o, addr & 32'hffff_ffe0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                resp_i = 1'b0;
                tick();
                chk("wr_stall_beat", burst_o, exp_q[0]);
                chk("wr_stall_write_o", write_o, 1);
                chk("wr_stall_resp_o", resp_o, 0);
            end
            chk("wr_beat", burst_o, exp_q.pop_front());
            resp_i = 1'b1;
            tick();
        end
        resp_i = 1'b0;
        chk("wr_resp_o", resp_o, 1);
        chk("wr_write_o_done", write_o, 0);
        chk("wr_addr_stable", address_o, addr & 32'hffff_ffe0);
        write_i = 1'b0;
        tick();
        chk("wr_resp_o_pulse", resp_o, 0);
        chk("wr_idle_write_o", write_o, 0);
    endtask

    initial begin
        rst       = 1'b1;
        address_i = '0;
        line_i    = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        last_line = '0;
        tick();
        tick();
        chk("rst_read_o", read_o, 0);
        chk("rst_write_o", write_o, 0);
        chk("rst_resp_o", resp_o, 0);
        chk("rst_line_o", line_o, 0);
        chk("rst_burst_o", burst_o, 0);
        chk("rst_address_o", address_o, 0);
        rst = 1'b0;
        tick();

        // Zero-wait read with minimum latency.
        do_read(32'h0000_1234, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 0, 1'b1);

        // Write with three-cycle gaps between strobes.
        do_write(32'h0000_5678, {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
                                 64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000}, 3, 1'b0);

        // Back-to-back write then read; the read is presented in the idle cycle after resp_o.
        do_write(32'h0000_0040, {8{$urandom}}, 0, 1'b0);
        chk("b2b_idle_read_o", read_o, 0);
        do_read(32'h0000_0080, {8{$urandom}}, 1, 1'b0);

        // Reset after three beats of a read.
        read_i    = 1'b1;
        address_i = 32'h0000_0123;
        tick();
        read_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            tick();
        end
        resp_i = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_read_o", read_o, 0);
        chk("mid_rst_resp_o", resp_o, 0);
        chk("mid_rst_line_o", line_o, 0);
        chk("mid_rst_address_o", address_o, 0);
        tick();
        do_read(32'h0000_0A5F, {8{$urandom}}, 2, 1'b0);

        // Stray strobes while idle must not start or disturb anything.
        for (int k = 0; k < 3; k++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            tick();
            chk("stray_read_o", read_o, 0);
            chk("stray_write_o", write_o, 0);
            chk("stray_resp_o", resp_o, 0);
            chk("stray_line_o", line_o, last_line);
        end
        resp_i = 1'b0;
        do_read(32'hFFFF_FFFF, {8{$urandom}}, 0, 1'b1);

        // Read and write together: the write wins.
        do_write(32'h0000_0C00, {8{$urandom}}, 1, 1'b1);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
